serial_adder_ctrl: RTL and testbench

Bit-serial add/subtract sequencer built around a single 1-bit full adder slice (sum = a^b^c, carry = ((a^b)&c)|(a&b)). It accepts two WIDTH-bit operands over a valid/ready handshake and feeds them LSB-first through the slice, one bit per clock, with a registered carry. After WIDTH cycles it presents the WIDTH-bit result, carry-out and signed overflow on a second valid/ready handshake. It is the multi-bit arithmetic unit of the project datapath, trading latency for one-slice area.

---
 rtl/serial_adder_ctrl.sv | 133 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder slice, LSB-first, valid/ready in and out.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the `sub` port for a_in - b_in.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic              sub_op;
  logic              bit_a, bit_b, bit_sum, bit_carry;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_op = sub;
`else
  assign sub_op = 1'b0;
`endif

  // The single full-adder slice.
  assign bit_a     = a_sh_q[0];
  assign bit_b     = b_sh_q[0];
  assign bit_sum   = bit_a ^ bit_b ^ carry_q;
  assign bit_carry = ((bit_a ^ bit_b) & carry_q) | (bit_a & bit_b);

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_sh_d  = a_in;
          // Subtraction is A + ~B + 1; the caller's cin is not used then.
          b_sh_d  = sub_op ? ~b_in : b_in;
          carry_d = sub_op ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end

      StRun: begin
        result_d          = result_q >> 1;
        result_d[WIDTH-1] = bit_sum;
        a_sh_d            = a_sh_q >> 1;
        b_sh_d            = b_sh_q >> 1;
        carry_d           = bit_carry;
        cnt_d             = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          // carry_q here is the carry into the MSB.
          cout_d  = bit_carry;
          ovf_d   = carry_q ^ bit_carry;
          state_d = StDone;
        end
      end

      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8): vector table plus handshake/reset sequences.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  int passed;
  int total;
  int cyc;
  int acc_q[$];

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin      (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter and log of accept edges.
  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) acc_q.push_back(cyc);
    cyc <= cyc + 1;
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] exp_res;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic s);
    @(negedge clk);
    a_in     = a;
    b_in     = b;
    cin      = c;
    sub      = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Operands must have been captured on the accept edge.
    a_in = '1;
    b_in = '1;
    cin  = ~c;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) check("out_valid_timeout", 0, 1);
  endtask

  task automatic finish_op();
    @(posedge clk);
    #1;
    check("in_ready_after_hs", int'(in_ready), 1);
  endtask

  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic s, input logic [W-1:0] er, input logic ec,
                       input logic eo);
    int lat;
    start_op(a, b, c, s);
    // start_op returns 1 time unit after the accept edge; lat counts edges to out_valid.
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, lat, W);
    check({name, "_result"}, int'(result), int'(er));
    check({name, "_cout"}, int'(cout), int'(ec));
    check({name, "_ovf"}, int'(overflow), int'(eo));
    finish_op();
  endtask

  vec_t vecs[8];

  initial begin
    int lat;
    logic [W-1:0] held;
    int n_acc;

    passed    = 0;
    total     = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_in      = '0;
    b_in      = '0;
    cin       = 1'b0;
    sub       = 1'b0;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[7] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};

    // Reset state.
    #23;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_result", int'(result), 0);
    check("rst_cout", int'(cout), 0);
    check("rst_ovf", int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, 1'b0,
            vecs[i].exp_res, vecs[i].exp_cout, vecs[i].exp_ovf);
    end

`ifdef SERIAL_ADDER_SUB_EN
    do_op("sub_5_7", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    do_op("sub_80_1", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
`endif

    // Backpressure: DONE held with new operands offered.
    out_ready = 1'b0;
    start_op(8'h12, 8'h34, 1'b0, 1'b0);
    wait_done(lat);
    held  = result;
    check("bp_result", int'(result), 'h46);
    @(negedge clk);
    n_acc    = acc_q.size();
    a_in     = 8'hAA;
    b_in     = 8'h11;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_stable%0d", k), int'(result), int'(held));
      check($sformatf("bp_in_ready%0d", k), int'(in_ready), 0);
      check($sformatf("bp_out_valid%0d", k), int'(out_valid), 1);
    end
    check("bp_no_accept", acc_q.size(), n_acc);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    finish_op();

    // Reset while the fourth bit is in the slice.
    start_op(8'hF0, 8'h0F, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("rr_out_valid", int'(out_valid), 0);
    check("rr_in_ready", int'(in_ready), 1);
    check("rr_result", int'(result), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) check("rr_spurious_valid", int'(out_valid), 0);
    end
    do_op("after_rst", 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);

    // Back-to-back accepts with in_valid and out_ready held high.
    @(negedge clk);
    acc_q.delete();
    a_in     = 8'h21;
    b_in     = 8'h12;
    cin      = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 24; k++) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("b2b_accepts", acc_q.size(), 3);
    if (acc_q.size() >= 2) check("b2b_spacing", acc_q[1] - acc_q[0], W + 2);
    wait_done(lat);
    check("b2b_result", int'(result), 'h33);
    finish_op();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
